// File: rtl/fetch_ctrl_if.sv
// Fetch-path control bundle: hazard/redirect/halt inputs seen by the
// sequencer and the PC / IF-ID / ID-EX controls it produces.
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             MemRead_ex;
  logic [4:0]       Rt_ex;
  logic [4:0]       Rs_id;
  logic [4:0]       Rt_id;
  logic             Branch;
  logic             Jump;
  logic             Halt_id;
  logic             Resume;
  logic             MulBusy;
  logic             IFWrite;
  logic             IDWrite;
  logic             IF_ID_flush;
  logic             Bubble;
  logic             Halted;
  logic [CNT_W-1:0] StallCount;

  // Pipeline side: drives hazard/redirect inputs, consumes the enables.
  modport master (
    output MemRead_ex, Rt_ex, Rs_id, Rt_id, Branch, Jump, Halt_id, Resume, MulBusy,
    input  IFWrite, IDWrite, IF_ID_flush, Bubble, Halted, StallCount
  );

  // Sequencer side.
  modport slave (
    input  MemRead_ex, Rt_ex, Rs_id, Rt_id, Branch, Jump, Halt_id, Resume, MulBusy,
    output IFWrite, IDWrite, IF_ID_flush, Bubble, Halted, StallCount
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-path pipeline sequencer: boot hold-off, load-use stall, multiplier
// wait, branch/jump flush and halt/resume, plus a saturating stall counter.
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MUL_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam logic [3:0]       BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_next_s;
  logic [3:0]       boot_cnt_r;
  logic             resumed_r;   // halt instruction still in ID after resume
  logic             halted_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic luh_s;
  logic redir_s;
  logic if_write_s;
  logic id_write_s;
  logic flush_s;
  logic bubble_s;

  // A load into r0 never creates a dependency.
  assign luh_s   = bus.MemRead_ex & (bus.Rt_ex != 5'd0) &
                   ((bus.Rt_ex == bus.Rs_id) | (bus.Rt_ex == bus.Rt_id));
  assign redir_s = bus.Branch | bus.Jump;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state selection following the RUN priority order.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_BOOT: begin
        if (boot_cnt_r == BOOT_LAST) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_BOOT;
        end
      end
      ST_RUN: begin
        if (bus.MulBusy) begin
          state_next_s = ST_MUL_WAIT;
        end else if (luh_s) begin
          state_next_s = ST_RUN;
        end else if (bus.Halt_id && !resumed_r) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_MUL_WAIT: begin
        if (!bus.MulBusy) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_MUL_WAIT;
        end
      end
      ST_HALT: begin
        if (bus.Resume) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: state_next_s = ST_BOOT;
    endcase
  end

  // Pipeline enables; reset forces a held, bubbling pipe without flush.
  always_comb begin
    if_write_s = 1'b0;
    id_write_s = 1'b0;
    flush_s    = 1'b0;
    bubble_s   = 1'b1;
    if (reset) begin
      flush_s = 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          flush_s  = 1'b1;
          bubble_s = 1'b1;
        end
        ST_RUN: begin
          if (bus.MulBusy) begin
            bubble_s = 1'b0;
          end else if (luh_s) begin
            bubble_s = 1'b1;              // redirect deferred until operands forward
          end else if (resumed_r) begin
            if_write_s = 1'b1;            // halt leaves ID and enters EX as a nop
            id_write_s = 1'b1;
            bubble_s   = 1'b1;
          end else if (bus.Halt_id) begin
            bubble_s = 1'b1;
          end else if (redir_s) begin
            if_write_s = 1'b1;
            id_write_s = 1'b1;
            flush_s    = 1'b1;
            bubble_s   = 1'b0;
          end else begin
            if_write_s = 1'b1;
            id_write_s = 1'b1;
            bubble_s   = 1'b0;
          end
        end
        ST_MUL_WAIT: begin
          bubble_s = 1'b0;
        end
        ST_HALT: begin
          bubble_s = 1'b1;
        end
        default: begin
          bubble_s = 1'b1;
        end
      endcase
    end
  end

  // Boot hold-off counter, restarted only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boot_cnt_r <= 4'd0;
    end else if (state_r == ST_BOOT) begin
      boot_cnt_r <= boot_cnt_r + 4'd1;
    end else begin
      boot_cnt_r <= boot_cnt_r;
    end
  end

  // Halt mask: set on resume, dropped once the halt instruction leaves ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resumed_r <= 1'b0;
    end else if ((state_r == ST_HALT) && bus.Resume) begin
      resumed_r <= 1'b1;
    end else if ((state_r == ST_RUN) && id_write_s) begin
      resumed_r <= 1'b0;
    end else begin
      resumed_r <= resumed_r;
    end
  end

  // Registered halt status, tracking entry into and exit from HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= (state_next_s == ST_HALT);
    end
  end

  // Saturating count of fetch-stalled cycles while the core is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (((state_r == ST_RUN) || (state_r == ST_MUL_WAIT)) &&
                 !if_write_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.IFWrite     = if_write_s;
  assign bus.IDWrite     = id_write_s;
  assign bus.IF_ID_flush = flush_s;
  assign bus.Bubble      = bubble_s;
  assign bus.Halted      = halted_r;
  assign bus.StallCount  = stall_cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed stimulus, a behavioural model checked every
// cycle, and literal expectations at key points. A second instance with a
// 4-bit counter shares the stimulus to exercise saturation.
module tb_fetch_ctrl;

  localparam int BOOT_CYCLES = 2;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  fetch_ctrl_if #(.CNT_W(16)) bus ();
  fetch_ctrl_if #(.CNT_W(4))  bus4 ();

  fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  assign bus4.MemRead_ex = bus.MemRead_ex;
  assign bus4.Rt_ex      = bus.Rt_ex;
  assign bus4.Rs_id      = bus.Rs_id;
  assign bus4.Rt_id      = bus.Rt_id;
  assign bus4.Branch     = bus.Branch;
  assign bus4.Jump       = bus.Jump;
  assign bus4.Halt_id    = bus.Halt_id;
  assign bus4.Resume     = bus.Resume;
  assign bus4.MulBusy    = bus.MulBusy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_boot_edges;   // clock edges seen since reset release while booting
  bit m_mul;
  bit m_halt;
  bit m_resumed;
  int m_stall;

  always @(negedge clk) begin : cmp_blk
    logic e_if, e_id, e_fl, e_bub, luh, redir;
    int e_halted, e_cnt, e_cnt4;
    luh   = bus.MemRead_ex && (bus.Rt_ex != 5'd0) &&
            ((bus.Rt_ex == bus.Rs_id) || (bus.Rt_ex == bus.Rt_id));
    redir = bus.Branch || bus.Jump;
    e_halted = m_halt ? 1 : 0;
    e_cnt    = (m_stall > 65535) ? 65535 : m_stall;
    e_cnt4   = (m_stall > 15) ? 15 : m_stall;
    if (reset) begin
      {e_if, e_id, e_fl, e_bub} = 4'b0001;
      e_halted = 0; e_cnt = 0; e_cnt4 = 0;
    end else if (m_boot_edges < BOOT_CYCLES) {e_if, e_id, e_fl, e_bub} = 4'b0011;
    else if (m_halt)                         {e_if, e_id, e_fl, e_bub} = 4'b0001;
    else if (m_mul)                          {e_if, e_id, e_fl, e_bub} = 4'b0000;
    else if (bus.MulBusy)                    {e_if, e_id, e_fl, e_bub} = 4'b0000;
    else if (luh)                            {e_if, e_id, e_fl, e_bub} = 4'b0001;
    else if (m_resumed)                      {e_if, e_id, e_fl, e_bub} = 4'b1101;
    else if (bus.Halt_id)                    {e_if, e_id, e_fl, e_bub} = 4'b0001;
    else if (redir)                          {e_if, e_id, e_fl, e_bub} = 4'b1110;
    else                                     {e_if, e_id, e_fl, e_bub} = 4'b1100;

    check("IFWrite",     32'(bus.IFWrite),     32'(e_if));
    check("IDWrite",     32'(bus.IDWrite),     32'(e_id));
    check("IF_ID_flush", 32'(bus.IF_ID_flush), 32'(e_fl));
    check("Bubble",      32'(bus.Bubble),      32'(e_bub));
    check("Halted",      32'(bus.Halted),      32'(e_halted));
    check("StallCount",  32'(bus.StallCount),  32'(e_cnt));
    check("IFWrite4",    32'(bus4.IFWrite),    32'(e_if));
    check("IDWrite4",    32'(bus4.IDWrite),    32'(e_id));
    check("flush4",      32'(bus4.IF_ID_flush), 32'(e_fl));
    check("Bubble4",     32'(bus4.Bubble),     32'(e_bub));
    check("Halted4",     32'(bus4.Halted),     32'(e_halted));
    check("StallCount4", 32'(bus4.StallCount), 32'(e_cnt4));

    // advance the model to the state after the coming edge
    if (reset) begin
      m_boot_edges = 0; m_mul = 0; m_halt = 0; m_resumed = 0; m_stall = 0;
    end else if (m_boot_edges < BOOT_CYCLES) begin
      m_boot_edges++;
    end else if (m_halt) begin
      if (bus.Resume) begin
        m_halt = 0;
        m_resumed = 1;
      end
    end else begin
      if (!e_if) m_stall++;
      if (m_mul) begin
        if (!bus.MulBusy) m_mul = 0;
      end else begin
        if (bus.MulBusy) m_mul = 1;
        else if (!luh && bus.Halt_id && !m_resumed) m_halt = 1;
        if (e_id) m_resumed = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.MemRead_ex = 1'b0; bus.Rt_ex = 5'd0; bus.Rs_id = 5'd0; bus.Rt_id = 5'd0;
    bus.Branch = 1'b0; bus.Jump = 1'b0; bus.Halt_id = 1'b0; bus.Resume = 1'b0;
    bus.MulBusy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_boot_edges = 0; m_mul = 0; m_halt = 0; m_resumed = 0; m_stall = 0;
    reset = 1'b1;
    idle();
    repeat (2) step();
    #1;
    check("rst_ifwrite", 32'(bus.IFWrite), 32'd0);
    check("rst_bubble",  32'(bus.Bubble),  32'd1);
    check("rst_flush",   32'(bus.IF_ID_flush), 32'd0);

    // boot sequence
    step(); reset = 1'b0;
    #1 check("boot_e0_if", 32'(bus.IFWrite), 32'd0);
    step(); check("boot_e1_if", 32'(bus.IFWrite), 32'd0);
    step(); check("boot_e2_if", 32'(bus.IFWrite), 32'd1);
    check("boot_cnt", 32'(bus.StallCount), 32'd0);

    // load-use on rs
    bus.MemRead_ex = 1'b1; bus.Rt_ex = 5'd5; bus.Rs_id = 5'd5;
    #1 check("luh_if", 32'(bus.IFWrite), 32'd0);
    check("luh_bubble", 32'(bus.Bubble), 32'd1);
    step(); idle();
    check("luh_cnt", 32'(bus.StallCount), 32'd1);
    // Rt_ex = 0 never stalls
    bus.MemRead_ex = 1'b1; bus.Rt_ex = 5'd0; bus.Rs_id = 5'd0;
    #1 check("r0_if", 32'(bus.IFWrite), 32'd1);
    step(); idle();
    // load-use on rt
    bus.MemRead_ex = 1'b1; bus.Rt_ex = 5'd7; bus.Rs_id = 5'd2; bus.Rt_id = 5'd7;
    step(); idle();
    check("luh_rt_cnt", 32'(bus.StallCount), 32'd2);

    // load-use with branch: redirect deferred
    bus.MemRead_ex = 1'b1; bus.Rt_ex = 5'd3; bus.Rs_id = 5'd3; bus.Branch = 1'b1;
    #1 check("luhbr_flush", 32'(bus.IF_ID_flush), 32'd0);
    step(); idle(); bus.Branch = 1'b1;
    #1 check("br_flush", 32'(bus.IF_ID_flush), 32'd1);
    check("br_if", 32'(bus.IFWrite), 32'd1);
    step(); idle(); bus.Jump = 1'b1; bus.Resume = 1'b1;   // stray resume in RUN
    step(); idle();

    // multiplier wait
    bus.MulBusy = 1'b1;
    step(); check("mul_bubble", 32'(bus.Bubble), 32'd0);
    repeat (3) step();
    bus.MulBusy = 1'b0;
    step();
    check("mul_cnt", 32'(bus.StallCount), 32'd8);
    check("mul_back_if", 32'(bus.IFWrite), 32'd1);

    // halt / resume
    bus.Halt_id = 1'b1;
    #1 check("halt_if", 32'(bus.IFWrite), 32'd0);
    step(); check("halted", 32'(bus.Halted), 32'd1);
    bus.MemRead_ex = 1'b1; bus.Rt_ex = 5'd4; bus.Rs_id = 5'd4;
    repeat (10) step();
    bus.MemRead_ex = 1'b0;
    bus.Resume = 1'b1;
    step(); bus.Resume = 1'b0;
    check("resume_halted", 32'(bus.Halted), 32'd0);
    check("resume_if",     32'(bus.IFWrite), 32'd1);
    check("resume_bubble", 32'(bus.Bubble), 32'd1);
    check("halt_cnt",      32'(bus.StallCount), 32'd9);
    step(); bus.Halt_id = 1'b0;
    #1 check("post_resume_bubble", 32'(bus.Bubble), 32'd0);
    step();

    // reset during multiplier wait
    bus.MulBusy = 1'b1;
    step(); step();
    check("pre_rst_cnt", 32'(bus.StallCount), 32'd11);
    #2 reset = 1'b1;
    #1 check("midrst_if", 32'(bus.IFWrite), 32'd0);
    check("midrst_bubble", 32'(bus.Bubble), 32'd1);
    check("midrst_cnt", 32'(bus.StallCount), 32'd0);
    bus.MulBusy = 1'b0;
    step(); step(); reset = 1'b0;
    step(); check("reboot_e1_if", 32'(bus.IFWrite), 32'd0);
    step(); check("reboot_e2_if", 32'(bus.IFWrite), 32'd1);

    // counter saturation
    bus.MemRead_ex = 1'b1; bus.Rt_ex = 5'd9; bus.Rs_id = 5'd9;
    repeat (20) step();
    idle();
    check("sat16_cnt", 32'(bus.StallCount),  32'd20);
    check("sat4_cnt",  32'(bus4.StallCount), 32'd15);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
